// File: rtl/dcmac_packet_gen.sv
// dcmac_packet_gen: emits a burst of fixed-length Ethernet test frames on a
// standard AXI stream (BW = 16*SEG_COUNT bytes per beat).
// Frame layout: dst MAC, src MAC, EtherType, then the low byte of the absolute
// byte index for every payload byte.
// Optional build macro DCMAC_PKTGEN_SEQNUM_EN: bytes 14..17 carry a 32-bit
// per-frame sequence number, MSB first.
module dcmac_packet_gen #(
    parameter int SEG_COUNT = 2,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 9600
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       stop,
    input  logic [15:0]                packet_len,
    input  logic [31:0]                packet_count,
    input  logic [47:0]                dst_mac,
    input  logic [47:0]                src_mac,
    input  logic [15:0]                ethertype,
    output logic [SEG_COUNT*128-1:0]   axis_out_tdata,
    output logic [SEG_COUNT*16-1:0]    axis_out_tkeep,
    output logic                       axis_out_tlast,
    output logic                       axis_out_tvalid,
    input  logic                       axis_out_tready,
    output logic                       busy,
    output logic [31:0]                frames_sent
);
    localparam int BW     = 16 * SEG_COUNT;
    localparam int BW_LG  = $clog2(BW);
    localparam int BEAT_W = 16 - BW_LG;
    localparam logic [BEAT_W-1:0] BEAT_ONE = 1;
    localparam logic [BW-1:0]     KEEP_ONE = 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;

    logic [BEAT_W-1:0] beats_q;      // beats per frame
    logic [BEAT_W-1:0] beat_q;       // current beat within frame
    logic [BW_LG-1:0]  rem_q;        // len mod BW, selects last-beat tkeep
    logic [31:0]       remaining_q;
    logic [31:0]       frames_q;
    logic              stop_q;
    logic [111:0]      hdr_q;        // {dst, src, ethertype}, byte 0 at the top
    logic [15:0]       len_clamp;
    logic              accept, hs, last_beat, end_burst;
    logic [BW-1:0]     keep_v;

    // Clamp the requested length into [MIN_LEN, MAX_LEN]
    always_comb begin
        len_clamp = packet_len;
        if (packet_len < 16'(MIN_LEN))
            len_clamp = 16'(MIN_LEN);
        else if (packet_len > 16'(MAX_LEN))
            len_clamp = 16'(MAX_LEN);
    end

    // tvalid is purely a function of state, so hs uses the state directly
    assign accept    = (state == IDLE) && start && (packet_count != 32'd0);
    assign hs        = (state == SEND) && axis_out_tready;
    assign last_beat = (beat_q == beats_q - BEAT_ONE);
    assign end_burst = hs && last_beat && ((remaining_q == 32'd1) || stop_q || stop);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and stream control outputs
    always_comb begin
        state_nxt       = state;
        axis_out_tvalid = 1'b0;
        axis_out_tlast  = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: begin
                axis_out_tvalid = 1'b1;
                axis_out_tlast  = last_beat;
                busy            = 1'b1;
                if (end_burst) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst parameters, beat/frame counters and stop latch
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beats_q     <= '0;
            beat_q      <= '0;
            rem_q       <= '0;
            remaining_q <= '0;
            frames_q    <= '0;
            stop_q      <= 1'b0;
            hdr_q       <= '0;
        end else if (accept) begin
            beats_q     <= BEAT_W'((len_clamp + 16'(BW - 1)) >> BW_LG);
            beat_q      <= '0;
            rem_q       <= len_clamp[BW_LG-1:0];
            remaining_q <= packet_count;
            stop_q      <= 1'b0;
            hdr_q       <= {dst_mac, src_mac, ethertype};
        end else if (state == SEND) begin
            if (stop) stop_q <= 1'b1;
            if (hs) begin
                if (last_beat) begin
                    beat_q      <= '0;
                    remaining_q <= remaining_q - 32'd1;
                    frames_q    <= frames_q + 32'd1;
                    if (end_burst) stop_q <= 1'b0;
                end else begin
                    beat_q <= beat_q + BEAT_ONE;
                end
            end
        end
    end

    // Byte enables: full beats except a partial last beat; zero while idle
    always_comb begin
        keep_v = '1;
        if (last_beat && (rem_q != '0))
            keep_v = (KEEP_ONE << rem_q) - KEEP_ONE;
        if (state != SEND)
            keep_v = '0;
    end

    assign axis_out_tkeep = keep_v;
    assign frames_sent    = frames_q;

    // Per-byte-lane data: header, optional sequence number, index pattern.
    // The sequence number equals the completed-frame count, so frames_q is reused.
    for (genvar k = 0; k < BW; k++) begin : g_lane
        logic [15:0] j;
        logic [7:0]  b;
        assign j = {beat_q, BW_LG'(k)};
        // Select this lane's byte from its absolute frame index
        always_comb begin
            b = j[7:0];
            if (j < 16'd14)
                b = hdr_q[8*(4'd13 - j[3:0]) +: 8];
`ifdef DCMAC_PKTGEN_SEQNUM_EN
            else if (j < 16'd18)
                b = frames_q[8*(5'd17 - j[4:0]) +: 8];
`endif
        end
        assign axis_out_tdata[8*k +: 8] = keep_v[k] ? b : 8'h00;
    end

endmodule

// File: tb/tb_dcmac_packet_gen.sv
// Bench for dcmac_packet_gen (SEG_COUNT=2, BW=32): random headers/lengths and
// random backpressure, checked against a byte-level frame model.
`timescale 1ns/1ps
module tb_dcmac_packet_gen;
    localparam int SEG_COUNT = 2;
    localparam int BW        = 32;
    localparam int DW        = BW * 8;

    logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0]   packet_len = '0;
    logic [31:0]   packet_count = '0;
    logic [47:0]   dst_mac = '0, src_mac = '0;
    logic [15:0]   ethertype = '0;
    logic [DW-1:0] tdata;
    logic [BW-1:0] tkeep;
    logic          tlast, tvalid, busy;
    logic          tready = 1'b0;
    logic [31:0]   frames_sent;

    int vectors = 0, miscompares = 0;

    // model state: header sampled at the accepted start, completed frames
    logic [47:0] e_dst, e_src;
    logic [15:0] e_type;
    int          exp_frames = 0;

    // captured handshaked beats
    logic [DW-1:0] cap_data[$];
    logic [BW-1:0] cap_keep[$];
    logic          cap_last[$];
    int            stab_err;
    bit            timed_out;

    always #5 clk = ~clk;

    dcmac_packet_gen #(.SEG_COUNT(SEG_COUNT), .MIN_LEN(64), .MAX_LEN(9600)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .packet_len(packet_len), .packet_count(packet_count),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .axis_out_tdata(tdata), .axis_out_tkeep(tkeep), .axis_out_tlast(tlast),
        .axis_out_tvalid(tvalid), .axis_out_tready(tready),
        .busy(busy), .frames_sent(frames_sent)
    );

    function automatic int clampl(input int l);
        return (l < 64) ? 64 : ((l > 9600) ? 9600 : l);
    endfunction

    // Expected byte at absolute frame index j of a frame with sequence number seq
    function automatic logic [7:0] exp_byte(input int j, input int seq);
`ifdef DCMAC_PKTGEN_SEQNUM_EN
        logic [31:0] s;
        s = seq;
`endif
        if (j < 6)  return e_dst[8*(5-j) +: 8];
        if (j < 12) return e_src[8*(11-j) +: 8];
        if (j < 14) return e_type[8*(13-j) +: 8];
`ifdef DCMAC_PKTGEN_SEQNUM_EN
        if (j < 18) return s[8*(17-j) +: 8];
`else
        if (seq < 0) return 8'h00;
`endif
        return j[7:0];
    endfunction

    // Expected beat b of a frame of length lc
    function automatic void exp_beat(input int lc, input int seq, input int b,
                                     output logic [DW-1:0] d, output logic [BW-1:0] kp, output logic l);
        d  = '0;
        kp = '0;
        for (int k = 0; k < BW; k++) begin
            int j;
            j = b * BW + k;
            if (j < lc) begin
                kp[k]       = 1'b1;
                d[8*k +: 8] = exp_byte(j, seq);
            end
        end
        l = ((b + 1) * BW >= lc);
    endfunction

    // Pulse start with random header; scramble inputs afterwards to catch late sampling
    task automatic do_start(input int len, input int count);
        @(posedge clk); #1;
        dst_mac      = {16'($urandom()), $urandom()};
        src_mac      = {16'($urandom()), $urandom()};
        ethertype    = 16'($urandom());
        packet_len   = 16'(len);
        packet_count = count;
        e_dst = dst_mac; e_src = src_mac; e_type = ethertype;
        start = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        dst_mac      = {16'($urandom()), $urandom()};
        src_mac      = {16'($urandom()), $urandom()};
        ethertype    = 16'($urandom());
        packet_len   = 16'($urandom());
        packet_count = $urandom();
    endtask

    // Drive tready (ready_pct %), optionally pulse stop once after stop_at beats, record beats until busy drops
    task automatic collect(input int ready_pct, input int stop_at, input int max_cyc);
        logic [DW-1:0] hd;
        logic [BW-1:0] hk;
        logic          hl;
        bit hold, pulsed, done;
        hold = 0; pulsed = 0; done = 0; hd = '0; hk = '0; hl = 1'b0;
        cap_data.delete(); cap_keep.delete(); cap_last.delete();
        stab_err = 0; timed_out = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            if (!busy) done = 1;
            else begin
                if (hold && (tvalid !== 1'b1 || tdata !== hd || tkeep !== hk || tlast !== hl)) stab_err++;
                stop = 1'b0;
                if (stop_at >= 0 && !pulsed && cap_data.size() == stop_at) begin
                    stop = 1'b1; pulsed = 1;
                end
                tready = (int'($urandom_range(99)) < ready_pct);
                if (tvalid && tready) begin
                    cap_data.push_back(tdata); cap_keep.push_back(tkeep); cap_last.push_back(tlast);
                end
                hold = tvalid && !tready;
                hd = tdata; hk = tkeep; hl = tlast;
                @(posedge clk); #1;
            end
        end
        if (!done) timed_out = 1;
        stop = 1'b0;
        tready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; packet_count = 5; packet_len = 64;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        vectors++; if (tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
        vectors++; if (tkeep !== '0) begin miscompares++; $display("FAIL reset_tkeep: got %h expected 0", tkeep); end
        vectors++; if (tdata !== '0) begin miscompares++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (frames_sent !== 32'd0) begin miscompares++; $display("FAIL reset_frames: got %0d expected 0", frames_sent); end
        resetn = 1'b1;
        exp_frames = 0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        do_start(64, 1);
        collect(100, -1, 100);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout: got timeout expected done"); end
        vectors++; if (cap_data.size() != 2) begin miscompares++; $display("FAIL basic_beats: got %0d expected 2", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            exp_beat(64, exp_frames, i, ed, ek, el);
            vectors++;
            if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                miscompares++;
                $display("FAIL basic_beat[%0d]: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", i, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
            end
        end
        exp_frames += 1;
        vectors++; if (frames_sent !== 32'(exp_frames)) begin miscompares++; $display("FAIL basic_frames: got %0d expected %0d", frames_sent, exp_frames); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %b expected 0", busy); end
    endtask

    task automatic test_len65();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        do_start(65, 2);
        collect(100, -1, 100);
        vectors++; if (cap_data.size() != 6) begin miscompares++; $display("FAIL len65_beats: got %0d expected 6", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            exp_beat(65, exp_frames + i / 3, i % 3, ed, ek, el);
            vectors++;
            if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                miscompares++;
                $display("FAIL len65_beat[%0d]: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", i, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
            end
        end
        for (int f = 0; f < 2; f++) begin
            vectors++;
            if (cap_keep[3*f+2] !== 32'h00000001 || cap_data[3*f+2][7:0] !== 8'h40) begin
                miscompares++;
                $display("FAIL len65_byte64[%0d]: got keep=%h byte=%h expected keep=00000001 byte=40", f, cap_keep[3*f+2], cap_data[3*f+2][7:0]);
            end
        end
        exp_frames += 2;
        vectors++; if (frames_sent !== 32'(exp_frames)) begin miscompares++; $display("FAIL len65_frames: got %0d expected %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_clamp();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        int lens[2] = '{10, 20000};
        for (int t = 0; t < 2; t++) begin
            int lc, nb;
            lc = clampl(lens[t]);
            nb = (lc + BW - 1) / BW;
            do_start(lens[t], 1);
            collect(100, -1, 1000);
            vectors++; if (cap_data.size() != nb) begin miscompares++; $display("FAIL clamp_beats[%0d]: got %0d expected %0d", lens[t], cap_data.size(), nb); end
            for (int i = 0; i < cap_data.size(); i++) begin
                exp_beat(lc, exp_frames, i, ed, ek, el);
                vectors++;
                if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                    miscompares++;
                    $display("FAIL clamp_beat[%0d/%0d]: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", lens[t], i, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
                end
            end
            exp_frames += 1;
        end
        vectors++; if (cap_keep[299] !== '1) begin miscompares++; $display("FAIL clamp_lastkeep: got %h expected ffffffff", cap_keep[299]); end
    endtask

    task automatic test_ignore();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        @(posedge clk); #1;
        packet_count = 0; packet_len = 64; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (busy !== 1'b0 || tvalid !== 1'b0) begin miscompares++; $display("FAIL ignore_zero_count: got busy=%b tvalid=%b expected 0 0", busy, tvalid); end
        do_start(64, 3);
        packet_len = 200; packet_count = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        collect(100, -1, 200);
        vectors++; if (cap_data.size() != 6) begin miscompares++; $display("FAIL ignore_busy_start: got %0d beats expected 6", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            exp_beat(64, exp_frames + i / 2, i % 2, ed, ek, el);
            vectors++;
            if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                miscompares++;
                $display("FAIL ignore_beat[%0d]: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", i, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
            end
        end
        exp_frames += 3;
    endtask

    task automatic test_stop();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        int extra;
        // stop while idle must not carry into the next burst
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        do_start(64, 2);
        collect(100, -1, 100);
        vectors++; if (cap_data.size() != 4) begin miscompares++; $display("FAIL stop_idle: got %0d beats expected 4", cap_data.size()); end
        exp_frames += 2;
        // stop during the third frame of ten
        do_start(128, 10);
        collect(100, 9, 1000);
        vectors++; if (cap_data.size() != 12) begin miscompares++; $display("FAIL stop_beats: got %0d expected 12", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            exp_beat(128, exp_frames + i / 4, i % 4, ed, ek, el);
            vectors++;
            if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                miscompares++;
                $display("FAIL stop_beat[%0d]: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", i, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
            end
        end
        exp_frames += 3;
        vectors++; if (frames_sent !== 32'(exp_frames)) begin miscompares++; $display("FAIL stop_frames: got %0d expected %0d", frames_sent, exp_frames); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy: got %b expected 0", busy); end
        extra = 0;
        tready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (tvalid) extra++;
        end
        tready = 1'b0;
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL stop_quiet: got %0d valid cycles expected 0", extra); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        int len, lc, nb, lasts;
        len = int'($urandom_range(20, 300));
        lc  = clampl(len);
        nb  = (lc + BW - 1) / BW;
        do_start(len, 100);
        collect(50, -1, 20000);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL random_timeout: got timeout expected done"); end
        vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL random_stable: got %0d unstable stalls expected 0", stab_err); end
        lasts = 0;
        foreach (cap_last[i]) if (cap_last[i]) lasts++;
        vectors++; if (lasts != 100) begin miscompares++; $display("FAIL random_tlasts: got %0d expected 100", lasts); end
        vectors++; if (cap_data.size() != 100 * nb) begin miscompares++; $display("FAIL random_beats: got %0d expected %0d", cap_data.size(), 100 * nb); end
        for (int i = 0; i < cap_data.size(); i++) begin
            exp_beat(lc, exp_frames + i / nb, i % nb, ed, ek, el);
            vectors++;
            if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                miscompares++;
                $display("FAIL random_beat[%0d] len=%0d: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", i, lc, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
            end
        end
        exp_frames += 100;
        vectors++; if (frames_sent !== 32'(exp_frames)) begin miscompares++; $display("FAIL random_frames: got %0d expected %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        do_start(256, 5);
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        tready = 1'b0;
        exp_frames = 0;
        vectors++; if (tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== 32'd0) begin
            miscompares++;
            $display("FAIL resetmid_state: got tvalid=%b busy=%b frames=%0d expected 0 0 0", tvalid, busy, frames_sent);
        end
        do_start(64, 1);
        collect(100, -1, 100);
        vectors++; if (cap_data.size() != 2) begin miscompares++; $display("FAIL resetmid_beats: got %0d expected 2", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            exp_beat(64, exp_frames, i, ed, ek, el);
            vectors++;
            if ({cap_last[i], cap_keep[i], cap_data[i]} !== {el, ek, ed}) begin
                miscompares++;
                $display("FAIL resetmid_beat[%0d]: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h", i, cap_last[i], cap_keep[i], cap_data[i], el, ek, ed);
            end
        end
        exp_frames += 1;
    endtask

    task automatic test_seq();
        logic [DW-1:0] ed; logic [BW-1:0] ek; logic el;
        do_start(64, 3);
        collect(100, -1, 100);
        vectors++; if (cap_data.size() != 6) begin miscompares++; $display("FAIL seq_beats: got %0d expected 6", cap_data.size()); end
        for (int f = 0; f < 3; f++) begin
            exp_beat(64, exp_frames + f, 0, ed, ek, el);
            vectors++;
            if (cap_data[2*f][8*14 +: 32] !== ed[8*14 +: 32]) begin
                miscompares++;
                $display("FAIL seq_bytes14_17[%0d]: got %h expected %h", f, cap_data[2*f][8*14 +: 32], ed[8*14 +: 32]);
            end
        end
        exp_frames += 3;
        vectors++; if (frames_sent !== 32'(exp_frames)) begin miscompares++; $display("FAIL seq_frames: got %0d expected %0d", frames_sent, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len65();
        test_clamp();
        test_ignore();
        test_stop();
        test_random();
        test_reset_mid();
        test_seq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
